// File: rtl/div_unit.sv
// div_unit: iterative restoring 32-bit divider for MIPS DIV/DIVU, result {HI=rem, LO=quot}.
// Define DIV_EARLY_OUT_EN to finish in two edges when |dividend| < |divisor|.
module div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DZERO = 2'd1;
    localparam logic [1:0] ON    = 2'd2;
    localparam logic [1:0] S_END = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2*DATA_W:0]     wr_q, wr_d, wr_step, sh;
    logic [DATA_W:0]       trial;
    logic [DATA_W-1:0]     dvs_q, dvs_d, abs1, abs2, q_fix, r_fix;
    logic                  negq_q, negq_d, negr_q, negr_d;
    logic                  ready_q, ready_d, busy_q, early;
    logic [2*DATA_W-1:0]   result_q, result_d;

    assign abs1 = (signed_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign abs2 = (signed_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
`ifdef DIV_EARLY_OUT_EN
    assign early = (opdata2_i != '0) && (abs1 < abs2);
`else
    assign early = 1'b0;
`endif

    // One restoring step: shift, trial-subtract the divisor from the upper 33 bits.
    assign sh      = {wr_q[2*DATA_W-1:0], 1'b0};
    assign trial   = sh[2*DATA_W:DATA_W] - {1'b0, dvs_q};
    assign wr_step = (sh[2*DATA_W:DATA_W] >= {1'b0, dvs_q}) ? {trial, sh[DATA_W-1:1], 1'b1} : sh;
    assign q_fix   = negq_q ? -wr_step[DATA_W-1:0] : wr_step[DATA_W-1:0];
    assign r_fix   = negr_q ? -wr_step[2*DATA_W-1:DATA_W] : wr_step[2*DATA_W-1:DATA_W];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        dvs_d    = dvs_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        ready_d  = 1'b0;
        result_d = '0;
        if (state_q == IDLE) begin
            if (start_i && !annul_i) begin
                cnt_d  = '0;
                dvs_d  = abs2;
                negq_d = signed_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                negr_d = signed_i && opdata1_i[DATA_W-1];
                if (opdata2_i == '0 || early) begin
                    state_d = DZERO;
                    wr_d    = {{(DATA_W+1){1'b0}}, (opdata2_i == '0) ? '0 : opdata1_i};
                end else begin
                    state_d = ON;
                    wr_d    = {{(DATA_W+1){1'b0}}, abs1};
                end
            end
        end else if (annul_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == DZERO) begin
            state_d  = S_END;
            ready_d  = 1'b1;
            result_d = {wr_q[DATA_W-1:0], {DATA_W{1'b0}}};
        end else if (state_q == ON) begin
            wr_d  = wr_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W-1)) begin
                state_d  = S_END;
                ready_d  = 1'b1;
                result_d = {r_fix, q_fix};
            end
        end else begin
            state_d  = start_i ? S_END : IDLE;
            ready_d  = start_i;
            result_d = start_i ? result_q : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_q     <= '0;
            dvs_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            dvs_q    <= dvs_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            ready_q  <= ready_d;
            busy_q   <= (state_d != IDLE);
            result_q <= result_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = busy_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit covering signed/unsigned, div-by-zero, annul and reset.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst_n, start, sgn, annul;
    logic [31:0] op1, op2;
    logic [63:0] result;
    logic        ready, busy;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];

    div_unit dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .signed_i(sgn),
        .opdata1_i(op1), .opdata2_i(op2), .annul_i(annul),
        .result_o(result), .ready_o(ready), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] ua, ub, q, r;
        if (b == 0) return 64'h0;
        ua = (s && a[31]) ? -a : a;
        ub = (s && b[31]) ? -b : b;
        q  = ua / ub;
        r  = ua % ub;
        if (s && (a[31] ^ b[31])) q = -q;
        if (s && a[31]) r = -r;
        return {r, q};
    endfunction

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [63:0] exp, input int lat, input int hold);
        int edges;
        logic [63:0] e;
        @(negedge clk);
        op1 = a; op2 = b; sgn = s; start = 1'b1;
        sb.push_back(exp);
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 1) begin
                check("busy_edge1", {63'b0, busy}, 64'd1);
                op1 = ~a; op2 = $urandom; sgn = ~s;
            end
        end while (!ready && edges < 64);
        check("ready_seen", {63'b0, ready}, 64'd1);
        if (lat != 0) check("latency", 64'(edges), 64'(lat));
        e = sb.pop_front();
        check("result", result, e);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            check("hold_ready", {63'b0, ready}, 64'd1);
            check("hold_result", result, e);
        end
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        check("idle_busy", {63'b0, busy}, 64'd0);
        check("idle_ready", {63'b0, ready}, 64'd0);
        check("idle_result", result, 64'd0);
    endtask

    initial begin
        logic seen;
        logic [31:0] ra, rb;
        logic rs;
        int early_lat;
`ifdef DIV_EARLY_OUT_EN
        early_lat = 2;
`else
        early_lat = 33;
`endif
        rst_n = 1'b0; start = 1'b0; sgn = 1'b0; annul = 1'b0; op1 = '0; op2 = '0;
        #12;
        check("rst_result", result, 64'd0);
        check("rst_ready", {63'b0, ready}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        run_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 0);
        run_div(32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 0);
        run_div(32'd7, 32'hFFFFFFFE, 1'b1, {32'd1, 32'hFFFFFFFD}, 33, 0);
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'd0, 32'h80000000}, 33, 0);
        run_div(32'hFFFFFFFF, 32'd1, 1'b0, {32'd0, 32'hFFFFFFFF}, 33, 0);
        run_div(32'd1234, 32'd0, 1'b1, 64'd0, 2, 0);
        run_div(32'd5, 32'd9, 1'b0, {32'd5, 32'd0}, early_lat, 0);
        run_div(32'hFFFFFFFB, 32'd9, 1'b1, {32'hFFFFFFFB, 32'd0}, early_lat, 0);

        // Annul on the tenth ON edge, with start still high so annul must win.
        @(negedge clk);
        op1 = 32'd100; op2 = 32'd7; sgn = 1'b0; start = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk); annul = 1'b1;
        @(posedge clk); @(negedge clk);
        check("annul_busy", {63'b0, busy}, 64'd0);
        check("annul_ready", {63'b0, ready}, 64'd0);
        check("annul_result", result, 64'd0);
        annul = 1'b0; start = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); @(negedge clk);
            if (ready) seen = 1'b1;
        end
        check("annul_no_ready", {63'b0, seen}, 64'd0);

        run_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 5);

        // Asynchronous reset in the middle of an ON run.
        @(negedge clk);
        op1 = 32'd100; op2 = 32'd7; sgn = 1'b0; start = 1'b1;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {63'b0, busy}, 64'd0);
        check("arst_ready", {63'b0, ready}, 64'd0);
        check("arst_result", result, 64'd0);
        @(negedge clk); start = 1'b0; rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            ra = $urandom; rb = (i == 3) ? 32'd0 : $urandom >> (i * 3);
            rs = i[0];
            run_div(ra, rb, rs, model(ra, rb, rs), 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
